// File: rtl/key_pio_in_if.sv
// Avalon-MM slave bus bundle for the key input PIO.
//   address    word address (0 data, 1 reserved, 2 irqmask, 3 edgecapture)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   read data, zero latency
//   irq        level interrupt to the CPU
interface key_pio_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/key_pio_in.sv
// Push-key input PIO: per-bit synchroniser and debounce, readable debounced
// level, maskable per-bit edge capture driving a level IRQ.
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   in_port  raw asynchronous key pins
//   bus      Avalon-MM slave (address/chipselect/write_n/writedata in,
//            readdata/irq out; both outputs are combinational from regs)
module key_pio_in #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned RESET_LEVEL     = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  key_pio_in_if.slave      bus
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic RST_BIT = 1'(RESET_LEVEL);
  localparam logic [WIDTH-1:0] RST_VEC = {WIDTH{RST_BIT}};

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] db_d;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] ec;

  logic             wr;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] ev;
  logic [31:0]      rd;
  logic [31:0]      writedata_unused;

  // Only the low WIDTH bits of writedata are architected.
  assign writedata_unused = bus.writedata;

  assign wr = bus.chipselect & ~bus.write_n;

  // Two-stage synchroniser; only s2 feeds downstream logic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= RST_VEC;
      s2 <= RST_VEC;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

  // Per-bit debounce: db follows s2 only after DEBOUNCE_CYCLES of disagreement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db <= RST_VEC;
      for (int i = 0; i < int'(WIDTH); i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // db_d resets equal to db so reset release never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) db_d <= RST_VEC;
    else          db_d <= db;
  end

  assign fall = db_d & ~db;
  assign rise = ~db_d & db;

  // Edge selection.
  always_comb begin
    ev = fall | rise;
    if (EDGE_TYPE == 0)      ev = fall;
    else if (EDGE_TYPE == 1) ev = rise;
  end

  // Write-1-to-clear strobe for the edge capture register.
  always_comb begin
    clr = '0;
    if (wr && bus.address == 2'd3) clr = bus.writedata[WIDTH-1:0];
  end

  // Mask and edge capture; a new event outranks a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
      ec      <= '0;
    end else begin
      if (wr && bus.address == 2'd2) irqmask <= bus.writedata[WIDTH-1:0];
      ec <= (ec & ~clr) | ev;
    end
  end

  // Zero-latency read mux; decoded on address alone, no side effects.
  always_comb begin
    rd = '0;
    case (bus.address)
      2'd0:    rd = 32'(db);
      2'd2:    rd = 32'(irqmask);
      2'd3:    rd = 32'(ec);
      default: rd = '0;
    endcase
  end

  assign bus.readdata = rd;
  assign bus.irq      = |(ec & irqmask);

endmodule
